// File: rtl/pong_pkg.sv
// Shared types, constants and helpers for the ping-pong match sequencer.
package pong_pkg;

  // Match sequencer states. The numeric encoding is visible on game_state.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_WAIT      = 3'd4,
    ST_SCORED    = 3'd5,
    ST_PAUSED    = 3'd6,
    ST_GAME_OVER = 3'd7
  } state_t;

  // Two-axis 16-bit vector; x sits in the upper half when flattened.
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } vec2_t;

  // Physics score flags: bit0 means the right player scored, bit1 the left.
  localparam logic [1:0] SCORE_RIGHT = 2'b01;
  localparam logic [1:0] SCORE_LEFT  = 2'b10;

  // Winner encodings.
  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

  // Centre of a field given as {width, height}; halves each axis.
  function automatic vec2_t field_centre(input logic [31:0] dims);
    vec2_t c;
    c.x = dims[31:16] >> 1;
    c.y = dims[15:0] >> 1;
    return c;
  endfunction

  // Two's complement negation of one axis.
  function automatic logic [15:0] neg16(input logic [15:0] v);
    return ~v + 16'd1;
  endfunction

  // Score increment that sticks at 15 instead of wrapping.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/pong_match_controller_btn_edge.sv
// Rising-edge detector for an already-synchronised button level.
// The pulse is registered, so it appears in the cycle after the input rises.
module pong_btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  logic prev_q, prev_d;
  logic rise_q, rise_d;

  // Next values: remember the level, flag a low-to-high transition.
  always_comb begin
    prev_d = btn;
    rise_d = btn & ~prev_q;
  end

  // Edge detector state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/pong_match_controller.sv
// Match sequencer: owns ball position/velocity, requests one physics step
// per frame, and handles serve delay, pause, scoring and win detection.
module pong_match_controller
  import pong_pkg::*;
#(
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned PHYS_LATENCY = 1,
  parameter logic [15:0] INIT_VX      = 16'd5,
  parameter logic [15:0] INIT_VY      = 16'd5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start_btn,
  input  logic        pause_btn,
  input  logic [31:0] dimensions,
  input  logic [31:0] phys_pos_out,
  input  logic [31:0] phys_vel_out,
  input  logic [1:0]  phys_scored,
  output logic        phys_req,
  output logic [31:0] ball_pos,
  output logic [31:0] ball_vel,
  output logic [3:0]  score_left,
  output logic [3:0]  score_right,
  output logic [1:0]  winner,
  output logic [2:0]  game_state,
  output logic        frame_overrun
);

  localparam logic [15:0] SERVE_LOAD = 16'(SERVE_FRAMES);
  localparam logic [2:0]  WAIT_LOAD  = 3'(PHYS_LATENCY);
  localparam logic [3:0]  WIN_PTS    = 4'(WIN_SCORE);

  logic start_rise, pause_rise;

  state_t      state_q, state_d;
  vec2_t       pos_q, pos_d;
  vec2_t       vel_q, vel_d;
  vec2_t       centre;
  logic [3:0]  score_l_q, score_l_d;
  logic [3:0]  score_r_q, score_r_d;
  logic [3:0]  new_l, new_r;
  logic [1:0]  winner_q, winner_d;
  logic [1:0]  scored_q, scored_d;
  logic        phys_req_q, phys_req_d;
  logic        overrun_q, overrun_d;
  logic        serve_dir_q, serve_dir_d;   // 1 = serve toward +X
  logic        pend_q, pend_d;             // pause edge seen mid-step
  logic        pend_now;
  logic [15:0] serve_cnt_q, serve_cnt_d;
  logic [2:0]  wait_cnt_q, wait_cnt_d;
  logic        centred;

  pong_btn_edge u_start_edge (
    .clk  (clk),
    .rst  (rst),
    .btn  (start_btn),
    .rise (start_rise)
  );

  pong_btn_edge u_pause_edge (
    .clk  (clk),
    .rst  (rst),
    .btn  (pause_btn),
    .rise (pause_rise)
  );

  assign centre = field_centre(dimensions);

  // Next-state and datapath decisions for the match sequencer.
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    vel_d       = vel_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    winner_d    = winner_q;
    scored_d    = scored_q;
    phys_req_d  = 1'b0;
    overrun_d   = overrun_q;
    serve_dir_d = serve_dir_q;
    pend_d      = pend_q;
    serve_cnt_d = serve_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    new_l       = score_l_q;
    new_r       = score_r_q;
    // A pause edge arriving on the very cycle a step completes still counts.
    pend_now    = pend_q | pause_rise;

    unique case (state_q)
      ST_IDLE: begin
        pos_d = centre;
        vel_d = '0;
        if (start_rise) begin
          state_d     = ST_SERVE;
          serve_cnt_d = SERVE_LOAD;
        end
      end

      ST_SERVE: begin
        pos_d = centre;
        vel_d = '0;
        if (frame_tick) begin
          // A count of 0 or 1 both mean "serve on this tick".
          if (serve_cnt_q <= 16'd1) begin
            serve_cnt_d = '0;
            vel_d.x     = serve_dir_q ? INIT_VX : neg16(INIT_VX);
            vel_d.y     = INIT_VY;
            if (pend_q) begin
              state_d = ST_PAUSED;
              pend_d  = 1'b0;
            end else begin
              state_d = ST_PLAY;
            end
          end else begin
            serve_cnt_d = serve_cnt_q - 16'd1;
          end
        end
      end

      ST_PLAY: begin
        // Pause takes priority; a coincident tick is simply lost.
        if (pause_rise) begin
          state_d = ST_PAUSED;
        end else if (frame_tick) begin
          state_d    = ST_ISSUE;
          phys_req_d = 1'b1;
        end
      end

      ST_ISSUE: begin
        wait_cnt_d = WAIT_LOAD;
        state_d    = ST_WAIT;
        if (frame_tick) overrun_d = 1'b1;
        if (pause_rise) pend_d = 1'b1;
      end

      ST_WAIT: begin
        if (frame_tick) overrun_d = 1'b1;
        if (wait_cnt_q <= 3'd1) begin
          pos_d    = vec2_t'(phys_pos_out);
          vel_d    = vec2_t'(phys_vel_out);
          scored_d = phys_scored;
          if (phys_scored != 2'b00) begin
            state_d = ST_SCORED;
            pend_d  = pend_now;
          end else if (pend_now) begin
            state_d = ST_PAUSED;
            pend_d  = 1'b0;
          end else begin
            state_d = ST_PLAY;
            pend_d  = 1'b0;
          end
        end else begin
          wait_cnt_d = wait_cnt_q - 3'd1;
          if (pause_rise) pend_d = 1'b1;
        end
      end

      ST_SCORED: begin
        // Both flags together is treated as a fault: no point, same server.
        if (scored_q == SCORE_RIGHT) begin
          new_r       = sat_inc4(score_r_q);
          serve_dir_d = 1'b0;
        end else if (scored_q == SCORE_LEFT) begin
          new_l       = sat_inc4(score_l_q);
          serve_dir_d = 1'b1;
        end
        score_l_d = new_l;
        score_r_d = new_r;
        pos_d     = centre;
        vel_d     = '0;
        if (new_l == WIN_PTS) begin
          winner_d = WIN_LEFT;
          state_d  = ST_GAME_OVER;
        end else if (new_r == WIN_PTS) begin
          winner_d = WIN_RIGHT;
          state_d  = ST_GAME_OVER;
        end else begin
          state_d     = ST_SERVE;
          serve_cnt_d = SERVE_LOAD;
        end
      end

      ST_PAUSED: begin
        if (pause_rise) state_d = ST_PLAY;
      end

      ST_GAME_OVER: begin
        pos_d = centre;
        vel_d = '0;
        if (start_rise) begin
          score_l_d   = '0;
          score_r_d   = '0;
          winner_d    = WIN_NONE;
          overrun_d   = 1'b0;
          serve_dir_d = 1'b1;
          pend_d      = 1'b0;
          serve_cnt_d = SERVE_LOAD;
          state_d     = ST_SERVE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // All sequencer state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pos_q       <= '0;
      vel_q       <= '0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      winner_q    <= WIN_NONE;
      scored_q    <= '0;
      phys_req_q  <= 1'b0;
      overrun_q   <= 1'b0;
      serve_dir_q <= 1'b1;
      pend_q      <= 1'b0;
      serve_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      vel_q       <= vel_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      winner_q    <= winner_d;
      scored_q    <= scored_d;
      phys_req_q  <= phys_req_d;
      overrun_q   <= overrun_d;
      serve_dir_q <= serve_dir_d;
      pend_q      <= pend_d;
      serve_cnt_q <= serve_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  // While the ball is parked it tracks the live field centre, including
  // during reset when the registers cannot hold a data-dependent value.
  assign centred = (state_q == ST_IDLE) || (state_q == ST_SERVE) ||
                   (state_q == ST_GAME_OVER);

  assign ball_pos      = centred ? 32'(centre) : 32'(pos_q);
  assign ball_vel      = centred ? 32'd0 : 32'(vel_q);
  assign score_left    = score_l_q;
  assign score_right   = score_r_q;
  assign winner        = winner_q;
  assign game_state    = state_q;
  assign phys_req      = phys_req_q;
  assign frame_overrun = overrun_q;

endmodule

// File: tb/tb_pong_match_controller.sv
// Randomised self-checking bench for pong_match_controller.
module tb_pong_match_controller;

  localparam int SF = 3;
  localparam int WS = 7;
  localparam int PL = 2;

  localparam logic [31:0] S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_ISSUE = 3;
  localparam logic [31:0] S_SCORED = 5, S_PAUSED = 6, S_GAME_OVER = 7;

  logic        clk = 1'b0;
  logic        rst, frame_tick, start_btn, pause_btn;
  logic [31:0] dimensions, phys_pos_out, phys_vel_out;
  logic [1:0]  phys_scored;
  logic        phys_req, frame_overrun;
  logic [31:0] ball_pos, ball_vel;
  logic [3:0]  score_left, score_right;
  logic [1:0]  winner;
  logic [2:0]  game_state;

  int checks = 0;
  int errors = 0;

  // Reference model of the match.
  int          m_left, m_right, m_winner;
  bit          m_dir, m_ovr;
  logic [31:0] m_pos, m_vel;

  pong_match_controller #(
    .SERVE_FRAMES (SF),
    .WIN_SCORE    (WS),
    .PHYS_LATENCY (PL),
    .INIT_VX      (16'd5),
    .INIT_VY      (16'd5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .start_btn     (start_btn),
    .pause_btn     (pause_btn),
    .dimensions    (dimensions),
    .phys_pos_out  (phys_pos_out),
    .phys_vel_out  (phys_vel_out),
    .phys_scored   (phys_scored),
    .phys_req      (phys_req),
    .ball_pos      (ball_pos),
    .ball_vel      (ball_vel),
    .score_left    (score_left),
    .score_right   (score_right),
    .winner        (winner),
    .game_state    (game_state),
    .frame_overrun (frame_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] centre_of(input logic [31:0] d);
    int w, h;
    w = int'(d[31:16]);
    h = int'(d[15:0]);
    return {16'(w / 2), 16'(h / 2)};
  endfunction

  function automatic logic [31:0] serve_vel(input bit dir);
    return {16'(dir ? 5 : -5), 16'(5)};
  endfunction

  task automatic press_start();
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_pause();
    pause_btn = 1'b1;
    @(negedge clk);
    pause_btn = 1'b0;
    @(negedge clk);
  endtask

  task automatic tick_once();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  // Run the serve countdown; ball must stay parked until the last tick.
  task automatic do_serve();
    for (int i = 1; i <= SF; i++) begin
      check("serve_pos", ball_pos, centre_of(dimensions));
      check("serve_vel_zero", ball_vel, 32'd0);
      tick_once();
      if (i < SF) begin
        check("serve_wait", 32'(game_state), S_SERVE);
        repeat (2) @(negedge clk);
      end
    end
    check("serve_play", 32'(game_state), S_PLAY);
    check("serve_vel", ball_vel, serve_vel(m_dir));
    m_pos = centre_of(dimensions);
    m_vel = serve_vel(m_dir);
  endtask

  // Ticks while paused must not start a step or flag an overrun.
  task automatic paused_phase(input int n);
    for (int i = 0; i < n; i++) begin
      tick_once();
      check("paused_no_req", 32'(phys_req), 32'd0);
      check("paused_state", 32'(game_state), S_PAUSED);
      check("paused_pos", ball_pos, m_pos);
      check("paused_ovr", 32'(frame_overrun), 32'(m_ovr));
    end
  endtask

  // One physics step from PLAY, with optional overrun tick / pause edge.
  task automatic do_step(input logic [1:0] sc, input bit inj_tick, input bit inj_pause);
    logic [31:0] np, nv;
    np = $urandom;
    nv = $urandom;
    phys_pos_out = np;
    phys_vel_out = nv;
    phys_scored  = sc;
    tick_once();
    check("issue_state", 32'(game_state), S_ISSUE);
    check("issue_req", 32'(phys_req), 32'd1);
    check("issue_pos", ball_pos, m_pos);
    if (inj_tick) frame_tick = 1'b1;
    if (inj_pause) pause_btn = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    pause_btn  = 1'b0;
    if (inj_tick) m_ovr = 1'b1;
    check("req_one_cycle", 32'(phys_req), 32'd0);
    repeat (PL - 1) @(negedge clk);
    check("pre_latch_pos", ball_pos, m_pos);
    @(negedge clk);
    check("latch_pos", ball_pos, np);
    check("latch_vel", ball_vel, nv);
    m_pos = np;
    m_vel = nv;
    if (sc == 2'b00) begin
      check("step_state", 32'(game_state), inj_pause ? S_PAUSED : S_PLAY);
      check("step_ovr", 32'(frame_overrun), 32'(m_ovr));
      if (inj_pause) begin
        paused_phase(2);
        press_pause();
        check("resume_play", 32'(game_state), S_PLAY);
      end
    end else begin
      check("scored_state", 32'(game_state), S_SCORED);
      @(negedge clk);
      if (sc == 2'b01) begin
        if (m_right < 15) m_right++;
        m_dir = 1'b0;
      end else if (sc == 2'b10) begin
        if (m_left < 15) m_left++;
        m_dir = 1'b1;
      end
      if (m_left == WS) m_winner = 1;
      else if (m_right == WS) m_winner = 2;
      check("score_left", 32'(score_left), 32'(m_left));
      check("score_right", 32'(score_right), 32'(m_right));
      check("winner", 32'(winner), 32'(m_winner));
      check("after_score_state", 32'(game_state), (m_winner != 0) ? S_GAME_OVER : S_SERVE);
      check("after_score_pos", ball_pos, centre_of(dimensions));
      check("after_score_vel", ball_vel, 32'd0);
      check("step_ovr", 32'(frame_overrun), 32'(m_ovr));
    end
    $display("step: scored=%b tick=%0d pause=%0d L=%0d R=%0d state=%0d",
             sc, inj_tick, inj_pause, score_left, score_right, game_state);
    if (sc != 2'b00 && m_winner == 0) do_serve();
  endtask

  initial begin
    int steps;
    int r;
    logic [1:0] sc;
    rst = 1'b1;
    frame_tick = 1'b0;
    start_btn = 1'b0;
    pause_btn = 1'b0;
    dimensions = 32'h0280_01E0;
    phys_pos_out = '0;
    phys_vel_out = '0;
    phys_scored = '0;
    m_left = 0; m_right = 0; m_winner = 0; m_dir = 1'b1; m_ovr = 1'b0;
    m_pos = centre_of(dimensions);
    m_vel = '0;

    repeat (3) @(negedge clk);
    check("rst_state", 32'(game_state), S_IDLE);
    check("rst_req", 32'(phys_req), 32'd0);
    check("rst_pos", ball_pos, 32'h0140_00F0);
    check("rst_vel", ball_vel, 32'd0);
    check("rst_scores", {score_left, score_right}, 32'd0);
    check("rst_winner", 32'(winner), 32'd0);
    check("rst_ovr", 32'(frame_overrun), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    press_start();
    check("start_serve", 32'(game_state), S_SERVE);
    do_serve();

    press_start();
    check("start_ignored_play", 32'(game_state), S_PLAY);

    // Pause edge and tick in the same cycle: pause wins.
    pause_btn = 1'b1;
    @(negedge clk);
    pause_btn = 1'b0;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    check("pause_wins_state", 32'(game_state), S_PAUSED);
    check("pause_wins_req", 32'(phys_req), 32'd0);
    paused_phase(5);
    press_pause();
    check("unpause_play", 32'(game_state), S_PLAY);

    do_step(2'b00, 1'b1, 1'b1);
    do_step(2'b01, 1'b0, 1'b0);
    do_step(2'b11, 1'b0, 1'b0);

    steps = 0;
    while (m_winner == 0 && steps < 300) begin
      r = $urandom_range(0, 9);
      sc = (r <= 5) ? 2'b00 : (r <= 7) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
      do_step(sc, ($urandom_range(0, 7) == 0), (sc == 2'b00) && ($urandom_range(0, 5) == 0));
      steps++;
    end
    check("game_over_state", 32'(game_state), S_GAME_OVER);
    check("game_over_pos", ball_pos, centre_of(dimensions));

    press_start();
    m_left = 0; m_right = 0; m_winner = 0; m_dir = 1'b1; m_ovr = 1'b0;
    check("restart_state", 32'(game_state), S_SERVE);
    check("restart_scores", {score_left, score_right}, 32'd0);
    check("restart_winner", 32'(winner), 32'd0);
    check("restart_ovr", 32'(frame_overrun), 32'd0);
    do_serve();
    do_step(2'b10, 1'b0, 1'b0);

    // Reset in the middle of a step request.
    phys_pos_out = $urandom;
    tick_once();
    check("pre_rst_req", 32'(phys_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_req", 32'(phys_req), 32'd0);
    check("midrst_state", 32'(game_state), S_IDLE);
    check("midrst_scores", {score_left, score_right}, 32'd0);
    check("midrst_pos", ball_pos, centre_of(dimensions));
    dimensions = {16'($urandom_range(2, 4000)), 16'($urandom_range(2, 4000))};
    #1;
    check("midrst_pos_newdims", ball_pos, centre_of(dimensions));
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_idle", 32'(game_state), S_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
